// File: rtl/dcd_var_scan_if.sv
// Request/result bundle for the chunked decision-variable scanner.
// The master drives start/value/skip; the slave (scanner) returns status and results.
interface dcd_var_scan_if #(
  parameter int NUM   = 32,
  parameter int WIDTH = 3,
  parameter int CNT_W = $clog2(NUM + 1),
  parameter int IDX_W = $clog2(NUM)
);
  logic                 start_i;
  logic [NUM*WIDTH-1:0] value_i;
  logic [CNT_W-1:0]     skip_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 found_o;
  logic [NUM-1:0]       index_o;
  logic [IDX_W-1:0]     index_bin_o;
  logic [CNT_W-1:0]     free_cnt_o;

  modport master (
    output start_i, value_i, skip_i,
    input  busy_o, done_o, found_o, index_o, index_bin_o, free_cnt_o
  );

  modport slave (
    input  start_i, value_i, skip_i,
    output busy_o, done_o, found_o, index_o, index_bin_o, free_cnt_o
  );
endinterface

// File: rtl/dcd_var_scan.sv
// Multi-cycle free-variable selector: walks a captured snapshot CHUNK variables per cycle.
// Optional macro DCD_SCAN_ROTATE_EN enables skip_i (rank selection); otherwise the first free variable wins.
module dcd_var_scan #(
  parameter int NUM   = 32,
  parameter int WIDTH = 3,
  parameter int CHUNK = 8,
  parameter int CNT_W = $clog2(NUM + 1),
  parameter int IDX_W = $clog2(NUM)
) (
  input  logic           clk,
  input  logic           rst_n,
  dcd_var_scan_if.slave  bus
);

  localparam int P       = NUM / CHUNK;
  localparam int PTR_W   = (P > 1) ? $clog2(P) : 1;
  localparam int SLICE_W = CHUNK * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM*WIDTH-1:0] snap_q, snap_d;
  logic                 hit_q, hit_d;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;

  logic                 found_q, found_d;
  logic [NUM-1:0]       index_q, index_d;
  logic [IDX_W-1:0]     bin_q, bin_d;
  logic [CNT_W-1:0]     free_q, free_d;

  logic [CNT_W-1:0]     skip_eff;

`ifdef DCD_SCAN_ROTATE_EN
  logic [CNT_W-1:0]     skip_q, skip_d;
  assign skip_eff = skip_q;
`else
  logic                 unused_skip;
  assign skip_eff    = '0;
  assign unused_skip = ^bus.skip_i;
`endif

  // Decode slice: ripple the running count through one chunk, lowest index first.
  logic [SLICE_W-1:0]   slice_w;
  logic [CNT_W-1:0]     slice_cnt;
  logic                 slice_hit;
  logic [IDX_W-1:0]     slice_idx;

  always_comb begin
    slice_w   = snap_q[int'(ptr_q)*SLICE_W +: SLICE_W];
    slice_cnt = cnt_q;
    slice_hit = hit_q;
    slice_idx = hit_idx_q;
    for (int i = 0; i < CHUNK; i++) begin
      if (slice_w[i*WIDTH +: 2] == 2'b00) begin
        if (!slice_hit && (slice_cnt == skip_eff)) begin
          slice_hit = 1'b1;
          slice_idx = IDX_W'(int'(ptr_q) * CHUNK + i);
        end
        slice_cnt = slice_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    hit_d     = hit_q;
    hit_idx_d = hit_idx_q;
    found_d   = found_q;
    index_d   = index_q;
    bin_d     = bin_q;
    free_d    = free_q;
`ifdef DCD_SCAN_ROTATE_EN
    skip_d    = skip_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start_i) begin
          state_d   = S_SCAN;
          snap_d    = bus.value_i;
          ptr_d     = '0;
          cnt_d     = '0;
          hit_d     = 1'b0;
          hit_idx_d = '0;
`ifdef DCD_SCAN_ROTATE_EN
          skip_d    = bus.skip_i;
`endif
        end
      end
      S_SCAN: begin
        cnt_d     = slice_cnt;
        hit_d     = slice_hit;
        hit_idx_d = slice_idx;
        ptr_d     = ptr_q + PTR_W'(1);
        if (ptr_q == PTR_W'(P - 1)) begin
          state_d = S_DONE;
`ifdef DCD_SCAN_ROTATE_EN
          found_d = slice_hit;
`else
          found_d = (slice_cnt != '0);
`endif
          index_d = slice_hit ? (NUM'(1) << slice_idx) : '0;
          bin_d   = slice_hit ? slice_idx : '0;
          free_d  = slice_cnt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      found_q   <= 1'b0;
      index_q   <= '0;
      bin_q     <= '0;
      free_q    <= '0;
`ifdef DCD_SCAN_ROTATE_EN
      skip_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      found_q   <= found_d;
      index_q   <= index_d;
      bin_q     <= bin_d;
      free_q    <= free_d;
`ifdef DCD_SCAN_ROTATE_EN
      skip_q    <= skip_d;
`endif
    end
  end

  assign bus.busy_o      = (state_q == S_SCAN);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.found_o     = found_q;
  assign bus.index_o     = index_q;
  assign bus.index_bin_o = bin_q;
  assign bus.free_cnt_o  = free_q;

endmodule

// File: tb/tb_dcd_var_scan.sv
// Scoreboard bench for dcd_var_scan: directed snapshots, expected results queued at issue time.
module tb_dcd_var_scan;
  localparam int NUM   = 32;
  localparam int WIDTH = 3;
  localparam int CHUNK = 8;
  localparam int CNT_W = $clog2(NUM + 1);
  localparam int IDX_W = $clog2(NUM);
  localparam int LAT   = 5;

  typedef struct {
    string            name;
    logic             found;
    logic [NUM-1:0]   idx;
    logic [IDX_W-1:0] bin;
    logic [CNT_W-1:0] cnt;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcd_var_scan_if #(.NUM(NUM), .WIDTH(WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

  dcd_var_scan #(.NUM(NUM), .WIDTH(WIDTH), .CHUNK(CHUNK), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM*WIDTH-1:0] fill(input logic [WIDTH-1:0] w);
    logic [NUM*WIDTH-1:0] v;
    for (int k = 0; k < NUM; k++) v[k*WIDTH +: WIDTH] = w;
    return v;
  endfunction

  function automatic exp_t mk(input string name, input logic f, input logic [NUM-1:0] idx,
                              input logic [IDX_W-1:0] bin, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.name = name; e.found = f; e.idx = idx; e.bin = bin; e.cnt = cnt; e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done_o=1 at cycle %0d, required no pending scan", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
        chk({mon_e.name, "_found"}, 64'(bus.found_o), 64'(mon_e.found));
        chk({mon_e.name, "_index"}, 64'(bus.index_o), 64'(mon_e.idx));
        chk({mon_e.name, "_bin"}, 64'(bus.index_bin_o), 64'(mon_e.bin));
        chk({mon_e.name, "_cnt"}, 64'(bus.free_cnt_o), 64'(mon_e.cnt));
      end
    end
  end

  // Called at a negedge; returns one negedge later with start optionally still high.
  task automatic issue(input logic [NUM*WIDTH-1:0] v, input logic [CNT_W-1:0] sk,
                       input exp_t e, input bit hold);
    bus.start_i = 1'b1;
    bus.value_i = v;
    bus.skip_i  = sk;
    e.cyc = cyc + LAT;
    sb.push_back(e);
    @(negedge clk);
    chk({e.name, "_busy"}, 64'(bus.busy_o), 64'd1);
    if (!hold) bus.start_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    chk({name, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"},  64'(bus.busy_o), 64'd0);
    chk({name, "_done"},  64'(bus.done_o), 64'd0);
    chk({name, "_found"}, 64'(bus.found_o), 64'd0);
    chk({name, "_index"}, 64'(bus.index_o), 64'd0);
    chk({name, "_bin"},   64'(bus.index_bin_o), 64'd0);
    chk({name, "_cnt"},   64'(bus.free_cnt_o), 64'd0);
  endtask

  logic [NUM*WIDTH-1:0] v520, v31;
  exp_t e520_s0, e520_s1, e520_s2, e31;

  initial begin
    bus.start_i = 1'b0;
    bus.value_i = '0;
    bus.skip_i  = '0;

    v520 = fill(3'b010);
    v520[5*WIDTH +: WIDTH]  = 3'b000;
    v520[20*WIDTH +: WIDTH] = 3'b100;
    v31 = fill(3'b001);
    v31[0 +: WIDTH]         = 3'b011;
    v31[31*WIDTH +: WIDTH]  = 3'b000;

    e520_s0 = mk("v520_skip0", 1'b1, 32'h0000_0020, 5'd5, 6'd2);
`ifdef DCD_SCAN_ROTATE_EN
    e520_s1 = mk("v520_skip1", 1'b1, 32'h0010_0000, 5'd20, 6'd2);
    e520_s2 = mk("v520_skip2", 1'b0, 32'h0000_0000, 5'd0, 6'd2);
`else
    e520_s1 = mk("v520_skip1", 1'b1, 32'h0000_0020, 5'd5, 6'd2);
    e520_s2 = mk("v520_skip2", 1'b1, 32'h0000_0020, 5'd5, 6'd2);
`endif
    e31 = mk("only31", 1'b1, 32'h8000_0000, 5'd31, 6'd1);

    repeat (2) @(negedge clk);
    chk_zero("por");
    rst_n = 1'b1;
    @(negedge clk);

    issue(fill(3'b001), 6'd0, mk("all_false", 1'b0, 32'h0, 5'd0, 6'd0), 1'b0);
    drain("all_false");

    issue(v520, 6'd0, e520_s0, 1'b0);
    drain("v520_skip0");

    // Asynchronous reset mid-cycle while results are non-zero.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(v520, 6'd1, e520_s1, 1'b0);
    drain("v520_skip1");
    issue(v520, 6'd2, e520_s2, 1'b0);
    drain("v520_skip2");
    issue(v31, 6'd0, e31, 1'b0);
    drain("only31");

    // start held through SCAN with changing inputs: snapshot must not move.
    issue(v520, 6'd0, mk("hold", 1'b1, 32'h0000_0020, 5'd5, 6'd2), 1'b1);
    bus.value_i = fill(3'b000);
    bus.skip_i  = 6'd3;
    repeat (3) begin
      @(negedge clk);
      bus.value_i = ~bus.value_i;
    end
    bus.start_i = 1'b0;
    drain("hold");

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(v520, 6'd0, mk("b2b_first", 1'b1, 32'h0000_0020, 5'd5, 6'd2), 1'b0);
    repeat (LAT - 1) @(negedge clk);
    chk("b2b_done_cycle", 64'(bus.done_o), 64'd1);
    issue(v31, 6'd0, mk("b2b_second", 1'b1, 32'h8000_0000, 5'd31, 6'd1), 1'b0);
    drain("b2b");

    // Reset during chunk 2: scan aborted, no done afterwards.
    bus.start_i = 1'b1;
    bus.value_i = fill(3'b000);
    bus.skip_i  = 6'd0;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_busy", 64'(bus.busy_o), 64'd0);
    chk("midscan_done", 64'(bus.done_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(v520, 6'd1, e520_s1, 1'b0);
    drain("after_midscan");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcd_var_scan.md
# dcd_var_scan

Multi-cycle, parametrised decision-variable selector for the SAT engine state list. Captures the assignment words of NUM variables and walks them CHUNK at a time, lowest index first. It counts free variables and selects the free variable at a programmable rank. The result is returned as one-hot and binary index with a start/done handshake. This lets large variable banks share one narrow per-cycle decode slice instead of a fully combinational tree.

## Interface
Parameters:
- NUM, 32, variables scanned; must be a multiple of CHUNK
- WIDTH, 3, bits per variable word; bits [1:0] are the assignment, upper bits are ignored
- CHUNK, 8, variables decoded per scan cycle
- CNT_W, $clog2(NUM+1), free-count / rank width
- IDX_W, $clog2(NUM), binary index width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  request a scan; accepted only in IDLE or DONE
- value_i  in  NUM*WIDTH  variable words; variable k occupies [k*WIDTH +: WIDTH]; sampled on the accepting edge only
- skip_i  in  CNT_W  rank of the free variable to select (0 = first free); sampled with value_i
- busy_o  in  out  1  high while in SCAN
- done_o  out  1  one-cycle pulse; results valid
- found_o  out  1  a free variable of rank skip_i exists
- index_o  out  NUM  one-hot selected variable; all-zero if not found
- index_bin_o  out  IDX_W  binary selected index; 0 if not found
- free_cnt_o  out  CNT_W  total free variables in the captured snapshot

## Operation
- Assignment decode: 2'b00 free; 2'b01 false; 2'b10 true; 2'b11 illegal and treated as not free.
- FSM states:
  - IDLE: start_i=1 captures value_i/skip_i into a snapshot register, clears the running count and chunk pointer, then goes to SCAN.
  - SCAN: each cycle decodes chunk ptr, i.e. variables [ptr*CHUNK, ptr*CHUNK+CHUNK-1].
    - Within the chunk, the running count is carried variable-to-variable in ascending order.
    - The first variable whose pre-increment running count equals the latched skip and that is free is recorded; at most one match per scan.
    - Running count is increased by the chunk's free count.
    - After chunk P-1 (P = NUM/CHUNK) the FSM goes to DONE.
  - DONE: done_o=1 for exactly this cycle, then returns to IDLE. start_i=1 in DONE is accepted like in IDLE and goes straight to SCAN.
- start_i while in SCAN is ignored; the snapshot is not disturbed.
- Result outputs (found_o, index_o, index_bin_o, free_cnt_o) are registered. They update on the edge entering DONE and hold until the next DONE.
- Arithmetic: the running count cannot overflow with CNT_W = $clog2(NUM+1). If skip_i ≥ free count: found_o=0, index_o=0, index_bin_o=0, and free_cnt_o is still exact.
- Reset (asynchronous, any state including mid-scan): FSM → IDLE, count/pointer/snapshot cleared. busy_o=0, done_o=0, found_o=0, index_o=0, index_bin_o=0, free_cnt_o=0.

## Timing
- Accepting edge E0: start_i=1 in IDLE/DONE.
- busy_o high from after E0 until after edge E0+P.
- done_o high in the cycle after edge E0+P, i.e. latency P+1 edges (32/8 → 5).
- Back-to-back: start in the DONE cycle gives a throughput of one scan per P+1 cycles.
- Critical path: CHUNK-deep ripple of the running count through the decode slice; CHUNK trades area against cycles.

## Configuration
- DCD_SCAN_ROTATE_EN defined: skip_i is honoured as described, so the engine can rotate decisions over free variables.
- DCD_SCAN_ROTATE_EN undefined:
  - skip_i is ignored and the latched skip is forced to 0; the first free variable is always selected.
  - The skip register and its comparator are removed and the port remains but is unused.
  - found_o = (free_cnt_o != 0).

## Test plan
(NUM=32, WIDTH=3, CHUNK=8.)
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, then start with all words 3'b001 -> done_o at edge 5 with found_o=0, free_cnt_o=0, index_o=0.
- Variables 5 and 20 free, rest 3'b010, skip_i=0 -> found_o=1, index_bin_o=5, index_o=32'h0000_0020, free_cnt_o=2.
- Same snapshot with DCD_SCAN_ROTATE_EN:
  - skip_i=1 -> index_bin_o=20.
  - skip_i=2 -> found_o=0, free_cnt_o=2.
  - Without the macro, skip_i=1 -> index_bin_o=5.
- Boundary: only variable 31 free, variable 0 = 3'b011 (illegal) -> index_bin_o=31, index_o=32'h8000_0000, free_cnt_o=1.
- Handshake:
  - start_i held high during SCAN with changing value_i -> result reflects the original snapshot.
  - start_i=1 in the DONE cycle -> next done_o exactly 5 edges later.
- Reset mid-operation: rst_n low during SCAN chunk 2 -> busy_o=0 immediately and no done_o. A later start gives a correct result from a clean count.
